multicycle_ctrl_fsm: RTL and testbench

Sequencing controller for the multicycle build of the RV32I core. It replaces the single-cycle control unit.
- Steps the shared ALU, register file and unified instruction/data memory through fetch, decode, execute, memory and writeback states.
- Generates per-cycle datapath strobes and memory requests.
- Inserts memory wait states through a ready handshake, with a bus-timeout guard.

---
 rtl/multicycle_ctrl_fsm.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle RV32I sequencing controller with memory wait/timeout guard
// Optional macro ILLEGAL_TRAP_EN: unrecognised opcodes halt instead of executing as a NOP.
module multicycle_ctrl_fsm #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       bus_err,
    output logic       halted
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_t;

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_access;
    logic              timeout;
    logic [2:0]        alu_dec;

    assign in_access = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    // A completing access in the limit cycle is not a timeout.
    assign timeout   = in_access && !mem_ready && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            state <= next_state;
            if (in_access && !mem_ready && !timeout)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout)
                bus_err <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)    next_state = S_DECODE;
                else if (timeout) next_state = S_HALT;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      next_state = S_HALT;
`else
                    default:      next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)    next_state = S_MEMWB;
                else if (timeout) next_state = S_HALT;
            end
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready)    next_state = S_FETCH;
                else if (timeout) next_state = S_HALT;
            end
            S_EXECR, S_EXECI: next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_FETCH;
        endcase
    end

    // funct7b5 only selects sub for register-register ops (op[5] set).
    always_comb begin
        case (funct3)
            3'b000:  alu_dec = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = ALU_ADD;
        halted     = (state == S_HALT);
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = 2'b10;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = op[5] ? 2'b01 : 2'b00;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = alu_dec;
                end
                S_EXECI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ALUControl = alu_dec;
                end
                S_ALUWB: RegWrite = 1'b1;
                S_BEQ: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = ALU_SUB;
                    PCWrite    = zero;
                end
                S_JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       bus_err, halted;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl_fsm #(.MAX_WAIT(15), .WAIT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .bus_err(bus_err), .halted(halted)
    );

    always #5 clk = ~clk;

    // {mem_req,AdrSrc,MemWrite,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,bus_err,halted}
    function automatic logic [18:0] sig(input int mr, input int adr, input int mw, input int irw,
                                        input int pcw, input int rw, input int rs, input int sa,
                                        input int sb, input int imm, input int alu, input int be,
                                        input int h);
        return {mr[0], adr[0], mw[0], irw[0], pcw[0], rw[0], rs[1:0], sa[1:0], sb[1:0],
                imm[1:0], alu[2:0], be[0], h[0]};
    endfunction

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive inputs, check outputs, advance to next negedge.
    task automatic cyc(input string tag, input logic rdy, input logic z, input logic [18:0] exp);
        mem_ready = rdy;
        zero = z;
        #1;
        check(tag, {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
                    ALUSrcB, ImmSrc, ALUControl, bus_err, halted}, exp);
        @(negedge clk);
    endtask

    logic [18:0] ZERO_S, F_RDY, F_WAIT, DEC, ALUWB_S, MEMRD, MEMWB_S, MEMWR, JAL_S, HALT_S;

    task automatic insn(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
        cyc({tag, "_fetch"}, 1'b1, 1'b0, F_RDY);
        cyc({tag, "_decode"}, 1'b1, 1'b0, DEC);
    endtask

    initial begin
        ZERO_S  = sig(0,0,0,0,0,0,0,0,0,0,0,0,0);
        F_RDY   = sig(1,0,0,1,1,0,2,0,2,0,0,0,0);
        F_WAIT  = sig(1,0,0,0,0,0,2,0,2,0,0,0,0);
        DEC     = sig(0,0,0,0,0,0,0,1,1,2,0,0,0);
        ALUWB_S = sig(0,0,0,0,0,1,0,0,0,0,0,0,0);
        MEMRD   = sig(1,1,0,0,0,0,0,0,0,0,0,0,0);
        MEMWB_S = sig(0,0,0,0,0,1,1,0,0,0,0,0,0);
        MEMWR   = sig(1,1,1,0,0,0,0,0,0,0,0,0,0);
        JAL_S   = sig(0,0,0,0,1,0,0,1,2,0,0,0,0);
        HALT_S  = sig(0,0,0,0,0,0,0,0,0,0,0,0,1);

        reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cyc("reset_outputs", 1'b1, 1'b1, ZERO_S);
        reset = 1'b0;

        insn("add", 7'b0110011, 3'b000, 1'b0);
        cyc("add_execr", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,2,0,0,0,0,0));
        cyc("add_aluwb", 1'b1, 1'b0, ALUWB_S);

        insn("sub", 7'b0110011, 3'b000, 1'b1);
        cyc("sub_execr", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,2,0,0,1,0,0));
        cyc("sub_aluwb", 1'b1, 1'b0, ALUWB_S);

        insn("addi_f7", 7'b0010011, 3'b000, 1'b1);
        cyc("addi_execi", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,2,1,0,0,0,0));
        cyc("addi_aluwb", 1'b1, 1'b0, ALUWB_S);
        insn("slti", 7'b0010011, 3'b010, 1'b0);
        cyc("slti_execi", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,2,1,0,5,0,0));
        cyc("slti_aluwb", 1'b1, 1'b0, ALUWB_S);
        insn("ori", 7'b0010011, 3'b110, 1'b0);
        cyc("ori_execi", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,2,1,0,3,0,0));
        cyc("ori_aluwb", 1'b1, 1'b0, ALUWB_S);
        insn("and", 7'b0110011, 3'b111, 1'b0);
        cyc("and_execr", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,2,0,0,2,0,0));
        cyc("and_aluwb", 1'b1, 1'b0, ALUWB_S);
        insn("xori", 7'b0010011, 3'b100, 1'b0);
        cyc("xori_execi", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,2,1,0,0,0,0));
        cyc("xori_aluwb", 1'b1, 1'b0, ALUWB_S);

        insn("lw", 7'b0000011, 3'b010, 1'b0);
        cyc("lw_memadr", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,2,1,0,0,0,0));
        for (int i = 0; i < 3; i++) cyc("lw_memread_wait", 1'b0, 1'b0, MEMRD);
        cyc("lw_memread_done", 1'b1, 1'b0, MEMRD);
        cyc("lw_memwb", 1'b1, 1'b0, MEMWB_S);

        insn("sw", 7'b0100011, 3'b010, 1'b0);
        cyc("sw_memadr", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,2,1,1,0,0,0));
        cyc("sw_memwrite", 1'b1, 1'b0, MEMWR);

        insn("beq_t", 7'b1100011, 3'b000, 1'b0);
        cyc("beq_taken", 1'b1, 1'b1, sig(0,0,0,0,1,0,0,2,0,0,1,0,0));
        insn("beq_nt", 7'b1100011, 3'b000, 1'b0);
        cyc("beq_not_taken", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,2,0,0,1,0,0));

        insn("jal", 7'b1101111, 3'b000, 1'b0);
        cyc("jal_jal", 1'b1, 1'b0, JAL_S);
        cyc("jal_aluwb", 1'b1, 1'b0, ALUWB_S);

        insn("illegal", 7'b1111111, 3'b000, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        cyc("illegal_halt", 1'b1, 1'b0, HALT_S);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        cyc("illegal_back_fetch", 1'b0, 1'b0, F_WAIT);

        insn("sw_rst", 7'b0100011, 3'b010, 1'b0);
        cyc("sw_rst_memadr", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,2,1,1,0,0,0));
        cyc("sw_rst_wait0", 1'b0, 1'b0, MEMWR);
        cyc("sw_rst_wait1", 1'b0, 1'b0, MEMWR);
        reset = 1'b1;
        cyc("sw_rst_during_reset", 1'b0, 1'b0, ZERO_S);
        reset = 1'b0;

        // A stale counter after the abandoned write would time out early here.
        for (int i = 0; i < 16; i++) cyc("fetch_wait", 1'b0, 1'b0, F_WAIT);
        cyc("timeout_halt", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,0,0,0,0,1,1));
        cyc("halt_sticky", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,0,0,0,0,1,1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        cyc("after_reset_fetch", 1'b0, 1'b0, F_WAIT);

        for (int i = 0; i < 14; i++) cyc("limit_wait", 1'b0, 1'b0, F_WAIT);
        cyc("limit_ready_wins", 1'b1, 1'b0, F_RDY);
        cyc("limit_decode", 1'b1, 1'b0, DEC);
        cyc("limit_execr", 1'b1, 1'b0, sig(0,0,0,0,0,0,0,2,0,0,0,0,0));
        cyc("limit_aluwb", 1'b1, 1'b0, ALUWB_S);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
